// File: rtl/rr_pop_arbiter_pkg.sv
// rtl/rr_pop_arbiter_pkg.sv - shared FSM encoding, constants and helpers for rr_pop_arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int NUM_DST = 2;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pop_arbiter_if.sv
// rtl/rr_pop_arbiter_if.sv - source/destination FIFO boundary bundle for rr_pop_arbiter
interface rr_pop_arbiter_if #(
    parameter int DATA_SIZE = 6,
    parameter int NUM_SRC   = 4
);
    logic [NUM_SRC-1:0]             src_empty;
    logic [NUM_SRC*DATA_SIZE-1:0]   src_data;
    logic [NUM_SRC-1:0]             src_pop;
    logic [arb_pkg::NUM_DST-1:0]    dst_pause;
    logic [arb_pkg::NUM_DST-1:0]    dst_push;
    logic [DATA_SIZE-1:0]           dst_data;

    modport master (
        input  src_empty, src_data, dst_pause,
        output src_pop, dst_push, dst_data
    );

    modport slave (
        output src_empty, src_data, dst_pause,
        input  src_pop, dst_push, dst_data
    );
endinterface

// File: rtl/rr_pop_arbiter_grant.sv
// rtl/rr_pop_arbiter_grant.sv - round-robin pick: rotate requests, fixed-priority select, un-rotate
module rr_grant_logic #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);
    logic [NUM_SRC-1:0] rot_req;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W-1:0]   src_sel;
    logic               found;
    int                 base;

    always_comb begin
        base    = (int'(last_grant) + 1) % NUM_SRC;
        rot_req = '0;
        src_sel = '0;
        // Position 0 of rot_req is the source right after the last grant.
        for (int k = 0; k < NUM_SRC; k++) begin
            src_sel    = IDX_W'((base + k) % NUM_SRC);
            rot_req[k] = req[src_sel];
        end

        offset = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && rot_req[k]) begin
                found  = 1'b1;
                offset = IDX_W'(k);
            end
        end

        grant_idx = IDX_W'((base + int'(offset)) % NUM_SRC);
        grant     = '0;
        if (found) grant[grant_idx] = 1'b1;
        any_req   = found;
    end
endmodule

// File: rtl/rr_pop_arbiter.sv
// rtl/rr_pop_arbiter.sv - drains NUM_SRC source FIFOs round-robin into a pair of destination FIFOs
module rr_pop_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int NUM_SRC   = 4,
    parameter int DEST_BIT  = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    rr_pop_arbiter_if.master           bus,
    output logic [clog2(NUM_SRC)-1:0]  grant_idx,
    output logic                       idle,
    output logic [CNT_SIZE-1:0]        push_cnt_0,
    output logic [CNT_SIZE-1:0]        push_cnt_1
);
    localparam int IDX_W = clog2(NUM_SRC);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     pend_idx;
    logic                 pend_valid;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_req;
    logic                 issue;
    logic [DATA_SIZE-1:0] src_word [NUM_SRC];
    logic [DATA_SIZE-1:0] word;

    assign req = ~bus.src_empty;

    rr_grant_logic #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_idx  (pick_idx),
        .any_req    (any_req)
    );

    // Either destination may receive the word, so both pauses must be clear to pop.
    assign issue = !reset && enable && (state != DRAIN) && !(|bus.dst_pause) && any_req;
    assign bus.src_pop = issue ? pick : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_SRC - 1);
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            grant_idx  <= '0;
            push_cnt_0 <= '0;
            push_cnt_1 <= '0;
        end else begin
            state      <= state_nxt;
            pend_valid <= issue;
            if (issue) begin
                last_grant <= pick_idx;
                grant_idx  <= pick_idx;
                pend_idx   <= pick_idx;
            end
            push_cnt_0 <= push_cnt_0 + CNT_SIZE'(bus.dst_push[0]);
            push_cnt_1 <= push_cnt_1 + CNT_SIZE'(bus.dst_push[1]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = pend_valid ? DRAIN : IDLE;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The source presents the popped word one cycle after the pop.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word[i] = bus.src_data[i*DATA_SIZE +: DATA_SIZE];
        end
        word         = src_word[pend_idx];
        bus.dst_data = pend_valid ? word : '0;
        bus.dst_push = '0;
        if (pend_valid) bus.dst_push[word[DEST_BIT]] = 1'b1;
    end

    assign idle = (state != DRAIN) && !pend_valid && (&bus.src_empty);
endmodule

// File: tb/tb_rr_pop_arbiter.sv
// tb/tb_rr_pop_arbiter.sv - randomized scoreboard bench for rr_pop_arbiter
module tb_rr_pop_arbiter;
    localparam int DW = 6;
    localparam int NS = 4;
    localparam int DB = 4;
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] word;
        int            due;
    } exp_t;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    grant_idx;
    logic          idle;
    logic [CW-1:0] push_cnt_0;
    logic [CW-1:0] push_cnt_1;

    bit            done    = 1'b0;
    int            errors  = 0;
    int            checks  = 0;
    int            cyc     = 0;
    int            pop_src = -1;

    exp_t          exp_q[$];
    logic [DW-1:0] srcq [NS][$];
    logic [DW-1:0] src_out [NS];

    int            m_mode  = 0;
    int            m_last  = NS - 1;
    int            m_grant = 0;
    bit            m_pend  = 1'b0;
    logic [CW-1:0] m_cnt [2];

    rr_pop_arbiter_if #(.DATA_SIZE(DW), .NUM_SRC(NS)) bus ();

    rr_pop_arbiter #(
        .DATA_SIZE (DW),
        .NUM_SRC   (NS),
        .DEST_BIT  (DB),
        .CNT_SIZE  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .grant_idx  (grant_idx),
        .idle       (idle),
        .push_cnt_0 (push_cnt_0),
        .push_cnt_1 (push_cnt_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] dst_onehot(input logic [DW-1:0] w);
        return w[DB] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [NS-1:0] nonempty_vec();
        logic [NS-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v[i] = (srcq[i].size() != 0);
        return v;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_last   = NS - 1;
        m_grant  = 0;
        m_pend   = 1'b0;
        m_cnt[0] = '0;
        m_cnt[1] = '0;
        exp_q.delete();
    endtask

    task automatic monitor_cycle();
        logic [NS-1:0] ne;
        logic [NS-1:0] exp_pop;
        bit            issue;
        int            g;
        exp_t          e;

        ne = nonempty_vec();
        check("push_cnt_0", push_cnt_0, m_cnt[0]);
        check("push_cnt_1", push_cnt_1, m_cnt[1]);
        check("grant_idx", grant_idx, m_grant);
        check("idle", idle, (m_mode != 2) && !m_pend && (ne == '0));

        if (bus.dst_push != 2'b00) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL push_unexpected: got dst_push=%b dst_data=0x%0h, required no push at cycle %0d",
                         bus.dst_push, bus.dst_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("dst_push", bus.dst_push, dst_onehot(e.word));
                check("dst_data", bus.dst_data, e.word);
                m_cnt[e.word[DB]] = m_cnt[e.word[DB]] + 1'b1;
            end
        end else begin
            check("dst_data_quiet", bus.dst_data, 0);
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("push_missing", bus.dst_push, dst_onehot(e.word));
                m_cnt[e.word[DB]] = m_cnt[e.word[DB]] + 1'b1;
            end
        end

        issue   = enable && (m_mode != 2) && (bus.dst_pause == 2'b00) && (ne != '0);
        g       = -1;
        exp_pop = '0;
        if (issue) begin
            for (int k = 1; k <= NS; k++) begin
                int s;
                s = (m_last + k) % NS;
                if (g < 0 && ne[s]) g = s;
            end
        end
        if (g >= 0) exp_pop[g] = 1'b1;
        check("src_pop", bus.src_pop, exp_pop);

        pop_src = g;
        if (g >= 0) begin
            e.word  = srcq[g][0];
            e.due   = cyc + 1;
            exp_q.push_back(e);
            m_last  = g;
            m_grant = g;
        end

        case (m_mode)
            0:       if (enable) m_mode = 1;
            1:       if (!enable) m_mode = m_pend ? 2 : 0;
            default: m_mode = 0;
        endcase
        m_pend = issue;
    endtask

    always begin
        @(negedge clk or posedge reset);
        if (reset && clk) begin
            #1;
            check("arst_src_pop", bus.src_pop, 0);
            check("arst_dst_push", bus.dst_push, 0);
            check("arst_dst_data", bus.dst_data, 0);
            check("arst_cnt_0", push_cnt_0, 0);
            check("arst_cnt_1", push_cnt_1, 0);
            check("arst_grant_idx", grant_idx, 0);
            model_reset();
            pop_src = -1;
        end else begin
            cyc++;
            if (reset) begin
                model_reset();
                pop_src = -1;
                check("rst_src_pop", bus.src_pop, 0);
                check("rst_dst_push", bus.dst_push, 0);
                check("rst_cnt_0", push_cnt_0, 0);
                check("rst_cnt_1", push_cnt_1, 0);
                check("rst_grant_idx", grant_idx, 0);
                check("rst_idle", idle, nonempty_vec() == '0);
            end else begin
                monitor_cycle();
            end
            if (done) begin
                check("scoreboard_drained", exp_q.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            bus.src_empty[i]          = (srcq[i].size() == 0);
            bus.src_data[i*DW +: DW]  = src_out[i];
        end
    endtask

    task automatic push_word(input int s, input logic [DW-1:0] w);
        srcq[s].push_back(w);
        drive_src();
    endtask

    // Source FIFOs pop on the edge and show the word for the following cycle.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (pop_src >= 0 && srcq[pop_src].size() != 0) src_out[pop_src] = srcq[pop_src].pop_front();
            drive_src();
        end
    endtask

    initial begin
        bus.dst_pause = 2'b00;
        for (int i = 0; i < NS; i++) src_out[i] = '0;
        drive_src();
        step(2);
        #1 reset = 1'b0;

        enable = 1'b1;
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < 6; j++) push_word(s, DW'($urandom));
        step(30);

        for (int j = 0; j < 6; j++) push_word(2, 6'b010011);
        step(8);

        push_word(0, 6'b000101);
        push_word(0, 6'b000001);
        push_word(1, 6'b010110);
        step(1);
        bus.dst_pause = 2'b01;
        step(3);
        bus.dst_pause = 2'b00;
        step(5);

        push_word(1, 6'b110010);
        step(1);
        enable = 1'b0;
        step(4);

        enable = 1'b1;
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < 4; j++) push_word(s, DW'($urandom));
        step(3);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        step(20);

        for (int k = 0; k < 300; k++) begin
            enable           = ($urandom_range(0, 7) != 0);
            bus.dst_pause[0] = ($urandom_range(0, 7) == 0);
            bus.dst_pause[1] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) != 0) push_word(int'($urandom_range(0, NS - 1)), DW'($urandom));
            step(1);
        end

        enable        = 1'b1;
        bus.dst_pause = 2'b00;
        step(40);
        for (int j = 0; j < 260; j++) push_word(3, DW'($urandom) & 6'b101111);
        step(270);

        done = 1'b1;
        step(3);
        $display("FAIL monitor_finish: monitor did not reach summary");
        $fatal(1);
    end
endmodule
